// File: rtl/seg_pkg.sv
// Shared constants and hex decode for the 7-segment scan driver.
package seg_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Active-low g..a patterns for 0-9, A, b, C, d, E, F.
  localparam logic [6:0] SEG_HEX [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    return SEG_HEX[v];
  endfunction

endpackage

// File: rtl/seg_pwm_gen.sv
// Brightness PWM: free-running counter modulo 2^BRIGHT_W-1 with duty compare.
module seg_pwm_gen #(
  parameter int unsigned BRIGHT_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [BRIGHT_W-1:0] i_bright,
  output logic                o_duty
);

  localparam int unsigned PwmPeriod = (1 << BRIGHT_W) - 1;
  localparam logic [BRIGHT_W-1:0] PwmLast = BRIGHT_W'(PwmPeriod - 1);

  logic [BRIGHT_W-1:0] r_pwm_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pwm_cnt <= '0;
    end else if (r_pwm_cnt == PwmLast) begin
      r_pwm_cnt <= '0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + 1'b1;
    end
  end

  // Period of 2^W-1 makes 0 never on and all-ones always on.
  assign o_duty = (r_pwm_cnt < i_bright);

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed common-anode 7-segment scan driver with PWM dimming, blink and guard interval.
// Build option: define SEG_LZ_SUPPRESS_EN to enable leading-zero suppression.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 8,
  parameter int unsigned DIGIT_TICKS  = 100000,
  parameter int unsigned GUARD_TICKS  = 2000,
  parameter int unsigned BLINK_FRAMES = 50,
  parameter int unsigned BRIGHT_W     = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic [BRIGHT_W-1:0]     bright,
  output logic [7:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_tick
);

  localparam int unsigned TW  = (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;
  localparam int unsigned IW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned BCW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [TW-1:0]  TickLast   = TW'(DIGIT_TICKS - 1);
  localparam logic [TW-1:0]  GuardTicks = TW'(GUARD_TICKS);
  localparam logic [IW-1:0]  IdxLast    = IW'(NUM_DIGITS - 1);
  localparam logic [BCW-1:0] BlinkLast  = BCW'(BLINK_FRAMES - 1);

  if (GUARD_TICKS >= DIGIT_TICKS || NUM_DIGITS == 0 || NUM_DIGITS > 16 ||
      BLINK_FRAMES == 0) begin : g_param_check
    $error("seg_scan_driver: invalid parameter combination");
  end

  logic [TW-1:0]           r_tick_cnt;
  logic [IW-1:0]           r_idx;
  logic [BCW-1:0]          r_blink_cnt;
  logic                    r_blink_phase;
  logic [4*NUM_DIGITS-1:0] r_digits_sh;
  logic [NUM_DIGITS-1:0]   r_dp_sh;
  logic [NUM_DIGITS-1:0]   r_blank_sh;
  logic [NUM_DIGITS-1:0]   r_blink_sh;
  logic [BRIGHT_W-1:0]     r_bright_sh;
  logic [NUM_DIGITS-1:0]   r_an;
  logic [7:0]              r_seg;
  logic                    r_frame_tick;

  logic                    w_frame_start;
  logic                    w_slot_end;
  logic                    w_frame_end;
  logic [4*NUM_DIGITS-1:0] w_digits;
  logic [NUM_DIGITS-1:0]   w_dp;
  logic [NUM_DIGITS-1:0]   w_blank;
  logic [NUM_DIGITS-1:0]   w_blink;
  logic [BRIGHT_W-1:0]     w_bright;
  logic [NUM_DIGITS-1:0]   w_lz;
  logic [3:0]              w_cur_digit;
  logic                    w_duty;
  logic                    w_lit;

  assign w_frame_start = (r_tick_cnt == '0) && (r_idx == '0);
  assign w_slot_end    = (r_tick_cnt == TickLast);
  assign w_frame_end   = w_slot_end && (r_idx == IdxLast);

  // In the capture cycle itself the display already uses the values being captured.
  assign w_digits = w_frame_start ? digits     : r_digits_sh;
  assign w_dp     = w_frame_start ? dp_mask    : r_dp_sh;
  assign w_blank  = w_frame_start ? blank_mask : r_blank_sh;
  assign w_blink  = w_frame_start ? blink_mask : r_blink_sh;
  assign w_bright = w_frame_start ? bright     : r_bright_sh;

`ifdef SEG_LZ_SUPPRESS_EN
  always_comb begin : p_lz
    logic v_run;
    w_lz  = '0;
    v_run = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      v_run   = v_run && (w_digits[4*i +: 4] == 4'h0) && !w_dp[i];
      w_lz[i] = v_run;
    end
  end
`else
  assign w_lz = '0;
`endif

  seg_pwm_gen #(
    .BRIGHT_W(BRIGHT_W)
  ) u_pwm (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_bright(w_bright),
    .o_duty  (w_duty)
  );

  assign w_cur_digit = w_digits[{r_idx, 2'b00} +: 4];
  assign w_lit = (r_tick_cnt >= GuardTicks) && w_duty && !w_blank[r_idx] &&
                 !(w_blink[r_idx] && r_blink_phase) && !w_lz[r_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tick_cnt <= '0;
      r_idx      <= '0;
    end else if (w_slot_end) begin
      r_tick_cnt <= '0;
      r_idx      <= (r_idx == IdxLast) ? '0 : r_idx + 1'b1;
    end else begin
      r_tick_cnt <= r_tick_cnt + 1'b1;
    end
  end

  // Advancing at frame end means the new phase is in force from the next frame start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (w_frame_end) begin
      if (r_blink_cnt == BlinkLast) begin
        r_blink_cnt   <= '0;
        r_blink_phase <= ~r_blink_phase;
      end else begin
        r_blink_cnt <= r_blink_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_digits_sh <= '0;
      r_dp_sh     <= '0;
      r_blank_sh  <= '0;
      r_blink_sh  <= '0;
      r_bright_sh <= '0;
    end else if (w_frame_start) begin
      r_digits_sh <= digits;
      r_dp_sh     <= dp_mask;
      r_blank_sh  <= blank_mask;
      r_blink_sh  <= blink_mask;
      r_bright_sh <= bright;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_an         <= '1;
      r_seg        <= SEG_BLANK;
      r_frame_tick <= 1'b0;
    end else begin
      r_an         <= w_lit ? ~(NUM_DIGITS'(1) << r_idx) : '1;
      r_seg        <= {~w_dp[r_idx], hex_to_seg(w_cur_digit)};
      r_frame_tick <= w_frame_start;
    end
  end

  assign an         = r_an;
  assign seg_out    = r_seg;
  assign frame_tick = r_frame_tick;

endmodule
